// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the Execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// The pipeline is held through o_stall while the unit computes. The result
// is then presented for one cycle with o_valid.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous reset, active-low
//   i_start    EX-stage instruction is an M-extension op
//   i_funct3   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   i_rs1      operand A (multiplicand / dividend)
//   i_rs2      operand B (multiplier / divisor)
//   i_rd_addr  destination register of the op
//   i_flush    kill the in-flight op (redirect); has priority over i_start
//   o_stall    stall request to the hazard unit
//   o_valid    one-cycle pulse: o_result / o_rd_addr are valid
//   o_result   registered result, held until the next completion
//   o_rd_addr  registered destination address, held until the next completion
//
// Handshake: an op is accepted in IDLE when i_start & !i_flush. o_valid is
// high only in DONE, and only if that cycle is not flushed. i_start seen
// outside IDLE is the same stalled instruction and is ignored.
module muldiv_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd_addr
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [31:0] opb_q, opb_d;        // multiplicand (mul) or divisor (div)
    logic [63:0] acc_q, acc_d;        // product, or {remainder, quotient}
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic        accept, is_div, sign_a, sign_b, div_zero, div_ovf;
    logic [31:0] mag_a, mag_b, fast_res;
    logic [32:0] mul_sum, rem_shift, rem_diff;
    logic [63:0] acc_step, prod_fix;
    logic [31:0] quo_fix, rem_fix, final_res;

    // Start decode. MULHSU treats rs2 as unsigned; MULHU, DIVU and REMU treat both operands as unsigned.
    always_comb begin
        accept   = i_start & ~i_flush;
        is_div   = i_funct3[2];
        sign_a   = is_div ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
        sign_b   = is_div ? ~i_funct3[0] : ~i_funct3[1];
        neg_a_d  = sign_a & i_rs1[31];
        neg_b_d  = sign_b & i_rs2[31];
        mag_a    = neg_a_d ? (32'd0 - i_rs1) : i_rs1;
        mag_b    = neg_b_d ? (32'd0 - i_rs2) : i_rs2;
        div_zero = is_div & (i_rs2 == 32'd0);
        div_ovf  = is_div & ~i_funct3[0] & (i_rs1 == 32'h8000_0000) & (i_rs2 == 32'hFFFF_FFFF);
        if (div_zero) begin
            fast_res = i_funct3[1] ? i_rs1 : 32'hFFFF_FFFF;
        end else begin
            fast_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration of the datapath, applied to the current accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
        rem_shift = acc_q[63:31];
        rem_diff  = rem_shift - {1'b0, opb_q};
        if (funct3_q[2]) begin
            // Remainder is always below the divisor, so the kept difference fits in 32 bits.
            if (rem_shift >= {1'b0, opb_q}) begin
                acc_step = {rem_diff[31:0], acc_q[30:0], 1'b1};
            end else begin
                acc_step = {acc_q[62:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                acc_step = {mul_sum, acc_q[31:1]};
            end else begin
                acc_step = {1'b0, acc_q[63:1]};
            end
        end
    end

    // Sign correction of the final iteration's value. For MULHSU neg_b_q is 0.
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? (64'd0 - acc_step) : acc_step;
        quo_fix  = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_step[31:0]) : acc_step[31:0];
        rem_fix  = neg_a_q ? (32'd0 - acc_step[63:32]) : acc_step[63:32];
        case (funct3_q)
            3'b000:                 final_res = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[63:32];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = i_funct3;
                    rd_d     = i_rd_addr;
                    cnt_d    = 6'd0;
                    opb_d    = is_div ? mag_b : mag_a;
                    acc_d    = {32'd0, is_div ? mag_a : mag_b};
                    if (div_zero | div_ovf) begin
                        result_d = fast_res;
                        rd_out_d = i_rd_addr;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_d = final_res;
                        rd_out_d = rd_q;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            funct3_q <= 3'd0;
            rd_q     <= 5'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opb_q    <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            if (state_q == IDLE && accept) begin
                neg_a_q <= neg_a_d;
                neg_b_q <= neg_b_d;
            end
        end
    end

    // The gating with i_rst keeps the stall request low during reset, even while i_start is high.
    assign o_stall   = i_rst & (((state_q == IDLE) & accept) | (state_q == CALC));
    assign o_valid   = (state_q == DONE) & ~i_flush;
    assign o_result  = result_q;
    assign o_rd_addr = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit. A driver task issues ops and measures latency
// and stall length. A monitor pops the expected values from the scoreboard
// queues when o_valid is seen.
module tb_muldiv_unit;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [4:0]  i_rd_addr;
    logic        i_flush;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd_addr;

    muldiv_unit dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_funct3  (i_funct3),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_rd_addr (i_rd_addr),
        .i_flush   (i_flush),
        .o_stall   (o_stall),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_rd_addr (o_rd_addr)
    );

    // Clock / reset
    always #5 i_clk = ~i_clk;

    // Scoreboard
    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];
    logic [31:0] last_res;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model, written from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p_ss, p_su;
        logic [63:0]        p_uu;
        logic signed [31:0] as, bs;
        logic [31:0]        r;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub   = {32'd0, b};
        p_ss = sa * sb;
        p_su = sa * ub;
        p_uu = {32'd0, a} * {32'd0, b};
        as   = a;
        bs   = b;
        case (f3)
            3'd0: r = p_ss[31:0];
            3'd1: r = p_ss[63:32];
            3'd2: r = p_su[63:32];
            3'd3: r = p_uu[63:32];
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(as / bs);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(as % bs);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Monitor: compare every o_valid pulse against the scoreboard.
    always @(negedge i_clk) begin
        if (i_rst && o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'd0, o_valid}, 32'd0);
            end else begin
                check("result", o_result, exp_q.pop_front());
                check("rd_addr", {27'd0, o_rd_addr}, {27'd0, exp_rd_q.pop_front()});
            end
        end
    end

    // Driver: hold i_start like a stalled pipeline until the result appears.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int exp_lat);
        int lat;
        int stalls;
        bit seen;
        @(negedge i_clk);
        i_start   = 1'b1;
        i_funct3  = f3;
        i_rs1     = a;
        i_rs2     = b;
        i_rd_addr = rd;
        last_res  = model(f3, a, b);
        exp_q.push_back(last_res);
        exp_rd_q.push_back(rd);
        #1;
        stalls = o_stall ? 1 : 0;
        lat    = 0;
        seen   = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge i_clk);
            lat++;
            if (o_valid) seen = 1'b1;
            else if (o_stall) stalls++;
        end
        check({tag, "_stall_in_done"}, {31'd0, o_stall}, 32'd0);
        i_start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
    endtask

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        i_rst = 1'b0; i_start = 1'b0; i_flush = 1'b0;
        i_funct3 = 3'd0; i_rs1 = 32'd0; i_rs2 = 32'd0; i_rd_addr = 5'd0;
        repeat (3) @(negedge i_clk);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_rd", {27'd0, o_rd_addr}, 32'd0);
        i_rst = 1'b1;

        // Directed ops
        do_op("mul_7x-3",   3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 33);
        do_op("mul_ff",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 33);
        do_op("mulh_ff",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 33);
        do_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 33);
        do_op("mulhsu_ff",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 33);
        do_op("div_-7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 33);
        do_op("rem_-7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 33);
        do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd8, 33);
        do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd9, 33);
        do_op("div_5_0",    3'd4, 32'd5, 32'd0, 5'd10, 1);
        do_op("remu_5_0",   3'd7, 32'd5, 32'd0, 5'd11, 1);
        do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1);
        do_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1);

        // Flush in CALC at counter 10
        @(negedge i_clk);
        i_start = 1'b1; i_funct3 = 3'd0; i_rs1 = 32'd5; i_rs2 = 32'd6; i_rd_addr = 5'd20;
        repeat (11) @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b1; i_start = 1'b0;
        #1 check("flush_stall_cycle", {31'd0, o_stall}, 32'd1);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("flush_stall_drop", {31'd0, o_stall}, 32'd0);
        check("flush_result_held", o_result, last_res);
        repeat (4) begin
            @(negedge i_clk);
            check("flush_no_valid", {31'd0, o_valid}, 32'd0);
        end
        do_op("mul_3x4", 3'd0, 32'd3, 32'd4, 5'd14, 33);

        // Asynchronous reset at counter 20, with i_start still high
        @(negedge i_clk);
        i_start = 1'b1; i_funct3 = 3'd0; i_rs1 = 32'h1234; i_rs2 = 32'h5678; i_rd_addr = 5'd21;
        repeat (21) @(posedge i_clk);
        @(negedge i_clk);
        #1 i_rst = 1'b0;
        #1;
        check("arst_stall", {31'd0, o_stall}, 32'd0);
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_result", o_result, 32'd0);
        check("arst_rd", {27'd0, o_rd_addr}, 32'd0);
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        do_op("post_rst_mulhu", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 33);

        // Random ops, with an occasional zero divisor
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            do_op("rand", f3, a, b, 5'($urandom_range(1, 31)), lat_of(f3, a, b));
        end

        repeat (3) @(negedge i_clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
